// File: rtl/code_reader_mealy_pkg.sv
// Shared types and default constants for the code reader front end and the
// digit-counting FSM that consumes its strobes.
package code_reader_mealy_pkg;

  // Front-end FSM states.
  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    GAP,
    STUCK
  } state_t;

  // Default tuning, also reused by the counting FSM bench.
  localparam int unsigned DEF_MIN_HIGH     = 4;
  localparam int unsigned DEF_MAX_HIGH     = 1000;
  localparam int unsigned DEF_GAP_TIMEOUT  = 2000;
  localparam int unsigned DEF_MAX_DIGITS   = 3;
  localparam int unsigned DEF_PULSE_CYCLES = 1;

  // Larger of two sizes, used when one counter must cover both.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/code_reader_mealy_if.sv
// Sensor-side and strobe-side signals of the code reader front end.
interface code_reader_mealy_if;

  logic       bar;     // raw optical line, high = bar under sensor
  logic       D;       // digit strobe
  logic       C;       // read-completed strobe
  logic [1:0] digits;  // digits accepted in the current code
  logic       busy;    // front end not idle
  logic       fault;   // sensor stuck high

  // Drives the sensor line and watches the strobes.
  modport master (
    output bar,
    input  D,
    input  C,
    input  digits,
    input  busy,
    input  fault
  );

  // The front end itself.
  modport slave (
    input  bar,
    output D,
    output C,
    output digits,
    output busy,
    output fault
  );

endinterface

// File: rtl/code_reader_mealy_pulse_stretch.sv
// Stretches a one-cycle fire request into a registered strobe PULSE_CYCLES
// clocks wide, so a slower consumer clock still catches it.
module pulse_stretch #(
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic fire,
  output logic strobe
);

  localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CntW-1:0] Load = CntW'(PULSE_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            strobe_q;

  // Reload on a fire request, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (fire) begin
      cnt_d = Load;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Strobe is the registered "counter nonzero" flag; reset cuts it off at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= (cnt_d != '0);
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/code_reader_mealy.sv
// Mealy front end for the sticker/code reader: synchronizes the raw bar line,
// turns each long-enough bar into a digit (D strobe), ends the code after a
// long low gap (C strobe) and flags a sensor stuck high.
module code_reader_mealy
  import code_reader_mealy_pkg::*;
#(
  parameter int unsigned MIN_HIGH     = DEF_MIN_HIGH,
  parameter int unsigned MAX_HIGH     = DEF_MAX_HIGH,
  parameter int unsigned GAP_TIMEOUT  = DEF_GAP_TIMEOUT,
  parameter int unsigned MAX_DIGITS   = DEF_MAX_DIGITS,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input logic                clk,
  input logic                reset,
  code_reader_mealy_if.slave bus
);

  localparam int unsigned CntMax = max_u(MAX_HIGH, GAP_TIMEOUT);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // The run counter is cleared on entering a state, so the sample that caused
  // the entry is not counted: a high run of N samples leaves N-1 in the
  // counter when bar_s drops, and the N-th high sample sees N-2.
  localparam logic [CntW-1:0] AcceptCnt  = CntW'(MIN_HIGH - 1);
  localparam logic [CntW-1:0] StuckCnt   = CntW'(MAX_HIGH - 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(GAP_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntSat     = {CntW{1'b1}};
  localparam logic [1:0]      DigitMax   = 2'(MAX_DIGITS);

  logic            bar_meta_q;
  logic            bar_s_q;
  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      digits_q, digits_d;
  logic            fire_d;
  logic            fire_c;
  logic            d_strobe;
  logic            c_strobe;

  // Two-flop synchronizer for the asynchronous sensor line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_meta_q <= 1'b0;
      bar_s_q    <= 1'b0;
    end else begin
      bar_meta_q <= bus.bar;
      bar_s_q    <= bar_meta_q;
    end
  end

  // Next state, digit count and strobe requests (Mealy: fire on the transition).
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    fire_d   = 1'b0;
    fire_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bar_s_q) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (bar_s_q) begin
          // This sample would make the run longer than MAX_HIGH.
          if (cnt_q >= StuckCnt) begin
            state_d = STUCK;
          end
        end else if (cnt_q >= AcceptCnt) begin
          state_d = GAP;
          if (digits_q < DigitMax) begin
            digits_d = digits_q + 2'd1;
            fire_d   = 1'b1;
          end
        end else if (digits_q != 2'd0) begin
          // Glitch inside a code: keep waiting for the gap to expire.
          state_d = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (bar_s_q) begin
          state_d = HIGH;
        end else if (cnt_q >= TimeoutCnt) begin
          state_d  = IDLE;
          digits_d = 2'd0;
          fire_c   = 1'b1;
        end
      end
      STUCK: begin
        if (!bar_s_q) begin
          state_d  = IDLE;
          digits_d = 2'd0;
          fire_c   = (digits_q != 2'd0);
        end
      end
      default: begin
        state_d  = IDLE;
        digits_d = 2'd0;
      end
    endcase
  end

  // Run counter: cleared on any state change, saturating count otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE && cnt_q != CntSat) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // FSM, run counter and digit count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      digits_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
    end
  end

  pulse_stretch #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_d_pulse (
    .clk   (clk),
    .reset (reset),
    .fire  (fire_d),
    .strobe(d_strobe)
  );

  pulse_stretch #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_c_pulse (
    .clk   (clk),
    .reset (reset),
    .fire  (fire_c),
    .strobe(c_strobe)
  );

  assign bus.D      = d_strobe;
  assign bus.C      = c_strobe;
  assign bus.digits = digits_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.fault  = (state_q == STUCK);

endmodule
